// File: rtl/mem2p_fifo_ctrl.sv
// FWFT FIFO controller around an external 2-port memory
// (sync write port, async read port).
module mem2p_fifo_ctrl #(
  parameter int W      = 8,
  parameter int D      = 128,
  parameter int AF_LVL = D - 4,
  parameter int AE_LVL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [W-1:0]             wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(D+1)-1:0]   count,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     ovf_err,
  input  logic                     err_clr,
  output logic                     mem_we,
  output logic [$clog2(D)-1:0]     mem_waddr,
  output logic [W-1:0]             mem_wdata,
  output logic [$clog2(D)-1:0]     mem_raddr,
  input  logic [W-1:0]             mem_rdata
);

  localparam int DW = $clog2(D);
  localparam int CW = $clog2(D+1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [DW-1:0]   wr_ptr;
  logic [DW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic            push;
  logic            pop;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [DW-1:0] nxt(
    input logic [DW-1:0] p
  );
    return (p == DW'(D-1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready = (state_q != S_FULL);
  assign rd_valid = (state_q != S_EMPTY);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  assign mem_we    = push;
  assign mem_waddr = wr_ptr;
  assign mem_wdata = wr_data;
  assign mem_raddr = rd_ptr;
  assign rd_data   = mem_rdata;

  assign count        = cnt_q;
  assign almost_full  = (cnt_q >= CW'(AF_LVL));
  assign almost_empty = (cnt_q <= CW'(AE_LVL));
  assign ovf_err      = ovf_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: begin
        if (push) state_d = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (pop & !push & (cnt_q == CW'(1)))
          state_d = S_EMPTY;
        else if (push & !pop & (cnt_q == CW'(D-1)))
          state_d = S_FULL;
      end
      S_FULL: begin
        if (pop) state_d = S_PARTIAL;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case (1'b1)
        push & !pop: cnt_q <= cnt_q + 1'b1;
        pop & !push: cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
      // A new overflow beats a clear in the same cycle.
      if (wr_valid & ~wr_ready)
        ovf_q <= 1'b1;
      else if (err_clr)
        ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem2p_fifo_ctrl.sv
// Bench for mem2p_fifo_ctrl: D=128 and D=6 instances
// driven with shared stimulus, each against a queue model.
module tb_mem2p_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wv;
  logic [7:0] wd;
  logic       rr;
  logic       clr;

  always #5 clk = ~clk;

  logic       wr_a, rv_a, af_a, ae_a, ov_a, we_a;
  logic [7:0] rd_a, wdat_a, mrd_a, cnt_a;
  logic [6:0] wad_a, rad_a;
  logic       wr_b, rv_b, af_b, ae_b, ov_b, we_b;
  logic [7:0] rd_b, wdat_b, mrd_b;
  logic [2:0] cnt_b, wad_b, rad_b;

  logic [7:0] mem_a [128];
  logic [7:0] mem_b [6];

  always @(posedge clk) if (we_a) mem_a[wad_a] <= wdat_a;
  always @(posedge clk) if (we_b) mem_b[wad_b] <= wdat_b;
  assign mrd_a = mem_a[rad_a];
  assign mrd_b = mem_b[rad_b];

  mem2p_fifo_ctrl #(.W(8), .D(128)) u_a (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wv), .wr_ready(wr_a), .wr_data(wd),
    .rd_valid(rv_a), .rd_ready(rr), .rd_data(rd_a),
    .count(cnt_a), .almost_full(af_a),
    .almost_empty(ae_a), .ovf_err(ov_a),
    .err_clr(clr), .mem_we(we_a),
    .mem_waddr(wad_a), .mem_wdata(wdat_a),
    .mem_raddr(rad_a), .mem_rdata(mrd_a)
  );

  mem2p_fifo_ctrl #(
    .W(8), .D(6), .AF_LVL(5), .AE_LVL(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wv), .wr_ready(wr_b), .wr_data(wd),
    .rd_valid(rv_b), .rd_ready(rr), .rd_data(rd_b),
    .count(cnt_b), .almost_full(af_b),
    .almost_empty(ae_b), .ovf_err(ov_b),
    .err_clr(clr), .mem_we(we_b),
    .mem_waddr(wad_b), .mem_wdata(wdat_b),
    .mem_raddr(rad_b), .mem_rdata(mrd_b)
  );

  logic [31:0] o_cnt [2];
  logic [31:0] o_rd  [2];
  logic [31:0] o_wad [2];
  logic [31:0] o_rad [2];
  logic        o_rv  [2];
  logic        o_wr  [2];
  logic        o_ov  [2];
  logic        o_af  [2];
  logic        o_ae  [2];
  logic        o_we  [2];

  assign o_cnt[0] = 32'(cnt_a);
  assign o_cnt[1] = 32'(cnt_b);
  assign o_rd[0]  = 32'(rd_a);
  assign o_rd[1]  = 32'(rd_b);
  assign o_wad[0] = 32'(wad_a);
  assign o_wad[1] = 32'(wad_b);
  assign o_rad[0] = 32'(rad_a);
  assign o_rad[1] = 32'(rad_b);
  assign o_rv[0]  = rv_a;
  assign o_rv[1]  = rv_b;
  assign o_wr[0]  = wr_a;
  assign o_wr[1]  = wr_b;
  assign o_ov[0]  = ov_a;
  assign o_ov[1]  = ov_b;
  assign o_af[0]  = af_a;
  assign o_af[1]  = af_b;
  assign o_ae[0]  = ae_a;
  assign o_ae[1]  = ae_b;
  assign o_we[0]  = we_a;
  assign o_we[1]  = we_b;

  // Reference model: circular buffer + occupancy.
  int         md  [2] = '{128, 6};
  int         maf [2] = '{124, 5};
  int         mae [2] = '{4, 1};
  logic [7:0] mbuf [2][128];
  int         mhead [2];
  int         msize [2];
  int         mpush [2];
  int         mpop  [2];
  logic       mov   [2];

  int nchk  = 0;
  int nfail = 0;
  int wraps_a = 0;
  int wraps_b = 0;

  typedef struct {
    logic [2:0] ctl;
    logic [7:0] d;
    logic [7:0] cnt;
    logic [4:0] f;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp,
    input int          i
  );
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s D=%0d got %0d want %0d t=%0t",
               nm, md[i], act, exp, $time);
    end
  endtask

  task automatic post_chk(input int i);
    chk("count", o_cnt[i], msize[i], i);
    chk("rd_valid", 32'(o_rv[i]), 32'(msize[i] > 0), i);
    chk("wr_ready", 32'(o_wr[i]),
        32'(msize[i] < md[i]), i);
    chk("ovf_err", 32'(o_ov[i]), 32'(mov[i]), i);
    chk("almost_full", 32'(o_af[i]),
        32'(msize[i] >= maf[i]), i);
    chk("almost_empty", 32'(o_ae[i]),
        32'(msize[i] <= mae[i]), i);
    chk("waddr", o_wad[i], mpush[i] % md[i], i);
    chk("raddr", o_rad[i], mpop[i] % md[i], i);
  endtask

  task automatic step(
    input logic       v,
    input logic [7:0] d,
    input logic       r,
    input logic       c
  );
    logic ep [2];
    logic eo [2];
    wv = v; wd = d; rr = r; clr = c;
    #1;
    for (int i = 0; i < 2; i++) begin
      ep[i] = v && (msize[i] < md[i]);
      eo[i] = r && (msize[i] > 0);
      chk("mem_we", 32'(o_we[i]), 32'(ep[i]), i);
      if (msize[i] > 0)
        chk("rd_data", o_rd[i],
            32'(mbuf[i][mhead[i]]), i);
    end
    if (we_a && wad_a == 7'd127) wraps_a++;
    if (we_b && wad_b == 3'd5) wraps_b++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (eo[i]) begin
        mhead[i] = (mhead[i] + 1) % md[i];
        msize[i]--;
        mpop[i]++;
      end
      if (ep[i]) begin
        mbuf[i][(mhead[i] + msize[i]) % md[i]] = d;
        msize[i]++;
        mpush[i]++;
      end
      if (v && !ep[i]) mov[i] = 1'b1;
      else if (c) mov[i] = 1'b0;
      post_chk(i);
    end
  endtask

  // Asserts reset mid-cycle and checks it acts at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    wv = 1'b0; rr = 1'b0; clr = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_count", o_cnt[i], 0, i);
      chk("rst_rd_valid", 32'(o_rv[i]), 0, i);
      chk("rst_wr_ready", 32'(o_wr[i]), 1, i);
      chk("rst_ovf", 32'(o_ov[i]), 0, i);
      chk("rst_af", 32'(o_af[i]), 0, i);
      chk("rst_ae", 32'(o_ae[i]), 1, i);
      chk("rst_mem_we", 32'(o_we[i]), 0, i);
      mhead[i] = 0; msize[i] = 0;
      mpush[i] = 0; mpop[i]  = 0;
      mov[i]   = 1'b0;
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ctl = {wr_valid, rd_ready, err_clr}
    // f   = {rd_valid, wr_ready, ovf, af, ae}, D=6
    tbl[0]  = '{3'b100, 8'h11, 8'd1, 5'b11001};
    tbl[1]  = '{3'b100, 8'h22, 8'd2, 5'b11000};
    tbl[2]  = '{3'b100, 8'h33, 8'd3, 5'b11000};
    tbl[3]  = '{3'b100, 8'h44, 8'd4, 5'b11000};
    tbl[4]  = '{3'b100, 8'h55, 8'd5, 5'b11010};
    tbl[5]  = '{3'b100, 8'h66, 8'd6, 5'b10010};
    tbl[6]  = '{3'b100, 8'h77, 8'd6, 5'b10110};
    tbl[7]  = '{3'b001, 8'h00, 8'd6, 5'b10010};
    tbl[8]  = '{3'b101, 8'h88, 8'd6, 5'b10110};
    tbl[9]  = '{3'b110, 8'h99, 8'd5, 5'b11110};
    tbl[10] = '{3'b110, 8'hAA, 8'd5, 5'b11110};
    tbl[11] = '{3'b011, 8'h00, 8'd4, 5'b11000};
    tbl[12] = '{3'b010, 8'h00, 8'd3, 5'b11000};
    tbl[13] = '{3'b010, 8'h00, 8'd2, 5'b11000};
    tbl[14] = '{3'b010, 8'h00, 8'd1, 5'b11001};
    tbl[15] = '{3'b010, 8'h00, 8'd0, 5'b01001};
    tbl[16] = '{3'b010, 8'h00, 8'd0, 5'b01001};

    rst_n = 1'b0;
    wv = 1'b0; wd = 8'h00; rr = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    for (int k = 0; k < 17; k++) begin
      step(tbl[k].ctl[2], tbl[k].d,
           tbl[k].ctl[1], tbl[k].ctl[0]);
      chk("t_count", o_cnt[1], 32'(tbl[k].cnt), 1);
      chk("t_rd_valid", 32'(o_rv[1]), 32'(tbl[k].f[4]), 1);
      chk("t_wr_ready", 32'(o_wr[1]), 32'(tbl[k].f[3]), 1);
      chk("t_ovf", 32'(o_ov[1]), 32'(tbl[k].f[2]), 1);
      chk("t_af", 32'(o_af[1]), 32'(tbl[k].f[1]), 1);
      chk("t_ae", 32'(o_ae[1]), 32'(tbl[k].f[0]), 1);
    end

    // Reset in the middle of traffic.
    for (int k = 0; k < 3; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    do_reset();

    // Fill D=128, overflow, clear, drain.
    for (int k = 0; k < 128; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b0);
      if (k == 122) chk("af_at_123", 32'(af_a), 0, 0);
      if (k == 123) chk("af_at_124", 32'(af_a), 1, 0);
    end
    chk("full_count", 32'(cnt_a), 128, 0);
    chk("full_wr_ready", 32'(wr_a), 0, 0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("full_pop_count", 32'(cnt_a), 127, 0);
    chk("full_pop_ovf", 32'(ov_a), 1, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_alone", 32'(ov_a), 0, 0);
    step(1'b1, 8'h80, 1'b0, 1'b0);
    step(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("clr_vs_ovf", 32'(ov_a), 1, 0);
    for (int k = 0; k < 130; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained", 32'(rv_a), 0, 0);

    // Streaming at low occupancy, wraps the pointers.
    do_reset();
    wraps_a = 0;
    for (int k = 0; k < 3; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    for (int k = 0; k < 300; k++)
      step(1'b1, 8'(k + 3), 1'b1, 1'b0);
    chk("stream_count", 32'(cnt_a), 3, 0);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wraps_128", 32'(wraps_a >= 2), 1, 0);

    // Push+pop at count 5 holds occupancy.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 8'(k + 8'h40), 1'b0, 1'b0);
    step(1'b1, 8'h50, 1'b1, 1'b0);
    chk("pp_count5", 32'(cnt_a), 5, 0);
    step(1'b1, 8'h51, 1'b1, 1'b0);
    chk("pp_count5b", 32'(cnt_a), 5, 0);

    // Random traffic on both depths.
    do_reset();
    wraps_b = 0;
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    chk("wraps_6", 32'(wraps_b >= 1), 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
